// File: rtl/fx3_slfifo_emu.sv
// fx3_slfifo_emu_fifo: one socket buffer, single clock, show-ahead head word on rdat.
// Latency: a push shows in cnt one edge later; rdat always presents the current head.
// Backpressure: none inside; the caller never pushes when full nor pops when empty.
module fx3_slfifo_emu_fifo #(
    parameter int W  = 34,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdat,
    output logic [W-1:0]  rdat,
    output logic [AW:0]   cnt
);
    logic [W-1:0]  mem [1<<AW];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdat;
    end

    // Reset flushes by clearing pointers and count; stale RAM contents are never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign rdat = mem[rptr];
endmodule

// fx3_slfifo_emu: FX3 GPIF-II synchronous slave-FIFO responder with host-side load/drain ports.
// Latency: read word on DQ_o 2 edges after the pop edge; flags and DQ_oe_o 1 edge after their cause.
// Backpressure: FPGA writes to a full socket are dropped (err_ovf_o); host drain holds while hs_rdy_i=0.
// Ports: FPGA bus (SLADDR_i, SLCSn_i, SLRDn_i, SLWRn_i, SLOEn_i, PKTENDn_i, DQ_i/DQ_o/DQ_oe_o, FLAGA..D_o),
//        host load of socket 0 (h_wr_i, h_dt_i, h_full_o), host drain of sockets 1..3 (hs_*),
//        saturating error counters (err_ovf_o, err_udf_o, err_proto_o).
module fx3_slfifo_emu #(
    parameter int DW   = 32,
    parameter int AW   = 10,
    parameter int WM   = 4,
    parameter int ERRW = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [1:0]      SLADDR_i,
    input  logic            SLCSn_i,
    input  logic            SLRDn_i,
    input  logic            SLWRn_i,
    input  logic            SLOEn_i,
    input  logic            PKTENDn_i,
    input  logic [DW-1:0]   DQ_i,
    output logic [DW-1:0]   DQ_o,
    output logic            DQ_oe_o,
    output logic            FLAGA_o,
    output logic            FLAGB_o,
    output logic            FLAGC_o,
    output logic            FLAGD_o,
    input  logic            h_wr_i,
    input  logic [DW-1:0]   h_dt_i,
    output logic            h_full_o,
    input  logic            hs_rdy_i,
    output logic            hs_vld_o,
    output logic [DW-1:0]   hs_dt_o,
    output logic [1:0]      hs_sck_o,
    output logic            hs_last_o,
    output logic            hs_zlp_o,
    output logic [ERRW-1:0] err_ovf_o,
    output logic [ERRW-1:0] err_udf_o,
    output logic [ERRW-1:0] err_proto_o
);
    localparam int          EW       = DW + 2;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(1 << AW);
    localparam logic [AW:0] WM_C     = (AW+1)'(WM);
    // free > WM  is the same as  count < DEPTH-WM
    localparam logic [AW:0] FREE_LIM = (AW+1)'((1 << AW) - WM);

    // ---------------- bus decode ----------------
    logic cs, rd, wr, bth, addr_nz, zlp_req, wr_req;
    assign cs      = ~SLCSn_i;
    assign addr_nz = |SLADDR_i;
    assign rd      = cs & ~SLRDn_i &  SLWRn_i;
    assign wr      = cs & ~SLWRn_i &  SLRDn_i;
    assign bth     = cs & ~SLRDn_i & ~SLWRn_i;
    assign zlp_req = cs &  SLWRn_i & ~PKTENDn_i & addr_nz;
    assign wr_req  = (wr & addr_nz) | zlp_req;

    // ---------------- socket 0 (FX3 producer) ----------------
    logic [DW-1:0] rdat0;
    logic [AW:0]   cnt0, cnt0_n;
    logic          push0, pop0, rd0;

    assign h_full_o = (cnt0 == DEPTH_C);
    assign push0    = h_wr_i & ~h_full_o;
    assign rd0      = rd & ~addr_nz;
    assign pop0     = rd0 & (cnt0 != '0);
    assign cnt0_n   = cnt0 + {{AW{1'b0}}, push0} - {{AW{1'b0}}, pop0};

    fx3_slfifo_emu_fifo #(.W(DW), .AW(AW)) u_sock0 (
        .clk(clk_i), .rst_n(rstn_i), .push(push0), .pop(pop0),
        .wdat(h_dt_i), .rdat(rdat0), .cnt(cnt0)
    );

    // ---------------- sockets 1..3 (FX3 consumers), index g is socket g+1 ----------------
    logic [EW-1:0] rdat_w [3];
    logic [AW:0]   cnt_w  [3];
    logic [2:0]    push_w, pop_w, full_w, ne_w, sel_w;
    logic [EW-1:0] wdat_w;
    logic          take;
    logic [1:0]    sck;

    assign wdat_w = zlp_req ? {2'b11, {DW{1'b0}}} : {1'b0, ~PKTENDn_i, DQ_i};

    for (genvar g = 0; g < 3; g++) begin : g_sock
        assign sel_w[g]  = (SLADDR_i == 2'(g + 1));
        assign full_w[g] = (cnt_w[g] == DEPTH_C);
        assign ne_w[g]   = (cnt_w[g] != '0);
        assign push_w[g] = wr_req & sel_w[g] & ~full_w[g];
        assign pop_w[g]  = take & (sck == 2'(g + 1));

        fx3_slfifo_emu_fifo #(.W(EW), .AW(AW)) u_sock (
            .clk(clk_i), .rst_n(rstn_i), .push(push_w[g]), .pop(pop_w[g]),
            .wdat(wdat_w), .rdat(rdat_w[g]), .cnt(cnt_w[g])
        );
    end

    // Count of the addressed write socket after this edge, for FLAGC/FLAGD.
    logic [AW:0] cnt_a, cnt_a_n;
    always_comb begin
        cnt_a = '0;
        case (SLADDR_i)
            2'd1:    cnt_a = cnt_w[0];
            2'd2:    cnt_a = cnt_w[1];
            2'd3:    cnt_a = cnt_w[2];
            default: cnt_a = '0;
        endcase
    end
    assign cnt_a_n = cnt_a + {{AW{1'b0}}, |(push_w & sel_w)} - {{AW{1'b0}}, |(pop_w & sel_w)};

    // ---------------- error events ----------------
    logic ovf_ev, udf_ev, proto_ev;
    assign ovf_ev   = wr_req & |(full_w & sel_w);
    assign udf_ev   = rd0 & (cnt0 == '0);
    assign proto_ev = bth | (rd & addr_nz) | (wr & ~addr_nz) | (wr & ~SLOEn_i);

    // ---------------- host drain, round-robin per word ----------------
    // lk freezes the offered socket while the host stalls, so a socket that becomes
    // non-empty earlier in round-robin order cannot swap the word under hs_vld_o.
    logic [1:0]    ptr, pick, lk_sck;
    logic          lk;
    logic [EW-1:0] head;

    always_comb begin
        pick = 2'd0;
        case (ptr)
            2'd2:    pick = ne_w[1] ? 2'd2 : ne_w[2] ? 2'd3 : ne_w[0] ? 2'd1 : 2'd0;
            2'd3:    pick = ne_w[2] ? 2'd3 : ne_w[0] ? 2'd1 : ne_w[1] ? 2'd2 : 2'd0;
            default: pick = ne_w[0] ? 2'd1 : ne_w[1] ? 2'd2 : ne_w[2] ? 2'd3 : 2'd0;
        endcase
    end

    assign sck      = lk ? lk_sck : pick;
    assign hs_vld_o = lk | (|ne_w);
    assign take     = hs_vld_o & hs_rdy_i;

    always_comb begin
        head = '0;
        case (sck)
            2'd1:    head = rdat_w[0];
            2'd2:    head = rdat_w[1];
            2'd3:    head = rdat_w[2];
            default: head = '0;
        endcase
    end

    assign hs_dt_o   = head[DW-1:0];
    assign hs_last_o = head[DW];
    assign hs_zlp_o  = head[DW+1];
    assign hs_sck_o  = sck;

    // ---------------- read pipe, flags, drain state ----------------
    logic          s1_vld, s2_vld;
    logic [DW-1:0] s1_dat, s2_dat;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr     <= 2'd1;
            lk      <= 1'b0;
            lk_sck  <= 2'd0;
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            DQ_o    <= '0;
            DQ_oe_o <= 1'b0;
            FLAGA_o <= 1'b0;
            FLAGB_o <= 1'b0;
            FLAGC_o <= 1'b0;
            FLAGD_o <= 1'b0;
        end else begin
            lk     <= hs_vld_o & ~hs_rdy_i;
            lk_sck <= sck;
            if (take) ptr <= (sck == 2'd3) ? 2'd1 : sck + 2'd1;

            s1_vld <= pop0;
            if (pop0) s1_dat <= rdat0;
            s2_vld <= s1_vld;
            s2_dat <= s1_dat;
            if (s2_vld) DQ_o <= s2_dat;

            DQ_oe_o <= cs & ~SLOEn_i;
            FLAGA_o <= (cnt0_n != '0);
            FLAGB_o <= (cnt0_n > WM_C);
            FLAGC_o <= addr_nz & (cnt_a_n != DEPTH_C);
            FLAGD_o <= addr_nz & (cnt_a_n < FREE_LIM);
        end
    end

    // ---------------- saturating error counters ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_ovf_o   <= '0;
            err_udf_o   <= '0;
            err_proto_o <= '0;
        end else begin
            if (ovf_ev   && (err_ovf_o   != '1)) err_ovf_o   <= err_ovf_o   + 1'b1;
            if (udf_ev   && (err_udf_o   != '1)) err_udf_o   <= err_udf_o   + 1'b1;
            if (proto_ev && (err_proto_o != '1)) err_proto_o <= err_proto_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_fx3_slfifo_emu.sv
module tb_fx3_slfifo_emu;
    localparam int DEPTH = 1024;
    localparam int WM    = 4;
    localparam int MAXE  = 65535;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  SLADDR_i;
    logic        SLCSn_i, SLRDn_i, SLWRn_i, SLOEn_i, PKTENDn_i;
    logic [31:0] DQ_i, DQ_o;
    logic        DQ_oe_o, FLAGA_o, FLAGB_o, FLAGC_o, FLAGD_o;
    logic        h_wr_i;
    logic [31:0] h_dt_i;
    logic        h_full_o;
    logic        hs_rdy_i, hs_vld_o;
    logic [31:0] hs_dt_o;
    logic [1:0]  hs_sck_o;
    logic        hs_last_o, hs_zlp_o;
    logic [15:0] err_ovf_o, err_udf_o, err_proto_o;

    fx3_slfifo_emu dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .SLADDR_i(SLADDR_i), .SLCSn_i(SLCSn_i),
        .SLRDn_i(SLRDn_i), .SLWRn_i(SLWRn_i), .SLOEn_i(SLOEn_i), .PKTENDn_i(PKTENDn_i),
        .DQ_i(DQ_i), .DQ_o(DQ_o), .DQ_oe_o(DQ_oe_o),
        .FLAGA_o(FLAGA_o), .FLAGB_o(FLAGB_o), .FLAGC_o(FLAGC_o), .FLAGD_o(FLAGD_o),
        .h_wr_i(h_wr_i), .h_dt_i(h_dt_i), .h_full_o(h_full_o),
        .hs_rdy_i(hs_rdy_i), .hs_vld_o(hs_vld_o), .hs_dt_o(hs_dt_o), .hs_sck_o(hs_sck_o),
        .hs_last_o(hs_last_o), .hs_zlp_o(hs_zlp_o),
        .err_ovf_o(err_ovf_o), .err_udf_o(err_udf_o), .err_proto_o(err_proto_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef logic [33:0] ent_t;   // {zlp, last, data}
    logic [31:0] q0[$];
    ent_t        q1[$], q2[$], q3[$];
    logic [31:0] pdat[$];
    int          pdue[$];
    int          cyc, ptr, hsck;
    logic        held;
    logic        e_vld;
    int          e_sck;
    ent_t        e_ent;
    logic [31:0] e_dq;
    logic        e_oe;
    logic [3:0]  e_flg;
    int          e_ovf, e_udf, e_proto;

    function automatic int qsize(input int s);
        case (s)
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return 0;
        endcase
    endfunction

    function automatic ent_t qfront(input int s);
        if (qsize(s) == 0) return '0;
        case (s)
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpop(input int s);
        case (s)
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            3: void'(q3.pop_front());
            default: ;
        endcase
    endtask

    task automatic qpush(input int s, input ent_t e);
        case (s)
            1: q1.push_back(e);
            2: q2.push_back(e);
            3: q3.push_back(e);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        pdat.delete(); pdue.delete();
        ptr = 1; held = 1'b0; hsck = 0;
        e_vld = 1'b0; e_sck = 0; e_ent = '0; e_dq = '0; e_oe = 1'b0; e_flg = '0;
        e_ovf = 0; e_udf = 0; e_proto = 0;
    endtask

    // Applies one clock edge using the inputs that were present at that edge.
    task automatic model_step();
        bit cs, rd, wr, bth, zq, pev, uev, oev;
        int a, pre0, prea;
        cyc++;
        if (!rstn_i) begin
            model_reset();
            return;
        end
        a    = int'(SLADDR_i);
        cs   = !SLCSn_i;
        rd   = cs && !SLRDn_i && SLWRn_i;
        wr   = cs && !SLWRn_i && SLRDn_i;
        bth  = cs && !SLRDn_i && !SLWRn_i;
        zq   = cs && SLWRn_i && !PKTENDn_i && (a != 0);
        pre0 = q0.size();
        prea = qsize(a);
        pev  = bth || (rd && a != 0) || (wr && a == 0) || (wr && !SLOEn_i);
        uev  = rd && a == 0 && pre0 == 0;
        oev  = 0;
        if (rd && a == 0 && pre0 > 0) begin
            pdat.push_back(q0.pop_front());
            pdue.push_back(cyc + 2);
        end
        if (h_wr_i && pre0 < DEPTH) q0.push_back(h_dt_i);
        if (e_vld && hs_rdy_i) begin
            qpop(e_sck);
            ptr = e_sck % 3 + 1;
        end
        if ((wr || zq) && a != 0) begin
            if (prea >= DEPTH) oev = 1;
            else if (zq) qpush(a, {2'b11, 32'h0});
            else qpush(a, {1'b0, !PKTENDn_i, DQ_i});
        end
        held = e_vld && !hs_rdy_i;
        hsck = e_sck;
        if (pdue.size() > 0 && pdue[0] == cyc) begin
            e_dq = pdat.pop_front();
            void'(pdue.pop_front());
        end
        e_oe  = cs && !SLOEn_i;
        e_flg = {q0.size() != 0, q0.size() > WM,
                 (a != 0) && (qsize(a) < DEPTH), (a != 0) && (DEPTH - qsize(a) > WM)};
        if (pev && e_proto < MAXE) e_proto++;
        if (uev && e_udf < MAXE)   e_udf++;
        if (oev && e_ovf < MAXE)   e_ovf++;
        if (held) e_sck = hsck;
        else begin
            e_sck = 0;
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (ptr - 1 + k) % 3 + 1;
                if (e_sck == 0 && qsize(s) > 0) e_sck = s;
            end
        end
        e_vld = (e_sck != 0);
        e_ent = qfront(e_sck);
    endtask

    task automatic compare_all();
        chk("dq", DQ_o, e_dq);
        chk("dq_oe", DQ_oe_o, e_oe);
        chk("flags", {FLAGA_o, FLAGB_o, FLAGC_o, FLAGD_o}, e_flg);
        chk("h_full", h_full_o, q0.size() == DEPTH);
        chk("hs_vld", hs_vld_o, e_vld);
        if (e_vld)
            chk("hs_word", {hs_sck_o, hs_zlp_o, hs_last_o, hs_dt_o},
                {e_sck[1:0], e_ent[33], e_ent[32], e_ent[31:0]});
        chk("err_ovf", err_ovf_o, e_ovf);
        chk("err_udf", err_udf_o, e_udf);
        chk("err_proto", err_proto_o, e_proto);
    endtask

    // Words taken by the host in the cycle just clocked.
    logic        tk, tk_last, tk_zlp;
    logic [31:0] tk_dt;

    task automatic cycle();
        tk      = hs_vld_o && hs_rdy_i;
        tk_dt   = hs_dt_o;
        tk_last = hs_last_o;
        tk_zlp  = hs_zlp_o;
        @(posedge clk_i);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle();
        SLCSn_i = 1'b1; SLRDn_i = 1'b1; SLWRn_i = 1'b1; SLOEn_i = 1'b1; PKTENDn_i = 1'b1;
        h_wr_i = 1'b0;
    endtask

    task automatic fpga_rd(input logic [1:0] a);
        SLCSn_i = 1'b0; SLRDn_i = 1'b0; SLWRn_i = 1'b1; SLOEn_i = 1'b0; PKTENDn_i = 1'b1;
        SLADDR_i = a;
    endtask

    task automatic fpga_wr(input logic [1:0] a, input logic [31:0] d, input logic pe_n);
        SLCSn_i = 1'b0; SLRDn_i = 1'b1; SLWRn_i = 1'b0; SLOEn_i = 1'b1; PKTENDn_i = pe_n;
        SLADDR_i = a; DQ_i = d;
    endtask

    logic [31:0] got_dt   [16];
    logic        got_last [16];
    logic        got_zlp  [16];
    logic [31:0] t4_exp   [9];
    int          n_got;

    initial begin
        cyc = 0;
        rstn_i = 1'b0; SLADDR_i = 2'd0; DQ_i = '0; h_dt_i = '0; hs_rdy_i = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        compare_all();
        chk("rst_flaga", FLAGA_o, 0);
        chk("rst_hs_vld", hs_vld_o, 0);
        rstn_i = 1'b1;

        // T1: host load 0..7, FPGA read burst
        for (int i = 0; i < 8; i++) begin
            h_wr_i = 1'b1; h_dt_i = i;
            cycle();
            if (i == 0) chk("t1_flaga_set", FLAGA_o, 1);
        end
        h_wr_i = 1'b0;
        cycle();
        chk("t1_flagb_set", FLAGB_o, 1);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) fpga_rd(2'd0);
            else idle();
            cycle();
            if (i == 0) chk("t1_dq_oe", DQ_oe_o, 1);
            if (i >= 2) chk("t1_dq", DQ_o, i - 2);
            if (i == 2) chk("t1_flagb_hi", FLAGB_o, 1);
            if (i == 3) chk("t1_flagb_lo", FLAGB_o, 0);
            if (i == 6) chk("t1_flaga_hi", FLAGA_o, 1);
            if (i == 7) chk("t1_flaga_lo", FLAGA_o, 0);
        end

        // T2: underflow and misaddressed read
        fpga_rd(2'd0); cycle();
        idle();
        repeat (3) cycle();
        chk("t2_udf", err_udf_o, 1);
        chk("t2_dq_hold", DQ_o, 7);
        fpga_rd(2'd2); cycle();
        idle(); cycle();
        chk("t2_proto", err_proto_o, 1);

        // T3: fill socket 1 past full with the host stalled
        hs_rdy_i = 1'b0;
        for (int i = 1; i <= 1025; i++) begin
            fpga_wr(2'd1, i, 1'b1);
            cycle();
            if (i == 1019) chk("t3_flagd_hi", FLAGD_o, 1);
            if (i == 1020) chk("t3_flagd_lo", FLAGD_o, 0);
            if (i == 1023) chk("t3_flagc_hi", FLAGC_o, 1);
            if (i == 1024) chk("t3_flagc_lo", FLAGC_o, 0);
        end
        idle(); cycle();
        chk("t3_ovf", err_ovf_o, 1);
        hs_rdy_i = 1'b1;
        repeat (1030) cycle();
        chk("t3_drained", hs_vld_o, 0);
        hs_rdy_i = 1'b0;

        // T6: asynchronous reset in the middle of a read burst
        for (int i = 0; i < 8; i++) begin
            h_wr_i = 1'b1; h_dt_i = 32'h60 + i;
            cycle();
        end
        h_wr_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fpga_rd(2'd0); cycle();
        end
        rstn_i = 1'b0;
        #2;
        model_reset();
        compare_all();
        chk("t6_rst_dq", DQ_o, 0);
        chk("t6_rst_flaga", FLAGA_o, 0);
        chk("t6_rst_oe", DQ_oe_o, 0);
        repeat (2) cycle();
        #2 rstn_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        idle();
        repeat (3) cycle();
        chk("t6_flaga", FLAGA_o, 0);
        chk("t6_no_stale", DQ_o, 0);
        chk("t6_udf", err_udf_o, 4);

        // T4: round-robin drain order
        for (int i = 0; i < 3; i++) begin
            fpga_wr(2'd1, 32'hA0 + i, 1'b1); cycle();
            fpga_wr(2'd2, 32'hB0 + i, 1'b1); cycle();
            fpga_wr(2'd3, 32'hC0 + i, 1'b1); cycle();
            t4_exp[3*i]   = 32'hA0 + i;
            t4_exp[3*i+1] = 32'hB0 + i;
            t4_exp[3*i+2] = 32'hC0 + i;
        end
        idle();
        hs_rdy_i = 1'b1;
        n_got = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (tk && n_got < 16) begin
                got_dt[n_got] = tk_dt;
                n_got++;
            end
        end
        chk("t4_count", n_got, 9);
        for (int i = 0; i < 9; i++) chk("t4_order", got_dt[i], t4_exp[i]);
        hs_rdy_i = 1'b0;

        // T5: PKTEND tagging, ZLP, and simultaneous strobes
        for (int i = 0; i < 6; i++) begin
            fpga_wr(2'd2, 32'h50 + i, (i == 5) ? 1'b0 : 1'b1);
            cycle();
        end
        SLCSn_i = 1'b0; SLRDn_i = 1'b1; SLWRn_i = 1'b1; SLOEn_i = 1'b1; PKTENDn_i = 1'b0;
        SLADDR_i = 2'd2;
        cycle();
        SLCSn_i = 1'b0; SLRDn_i = 1'b0; SLWRn_i = 1'b0; PKTENDn_i = 1'b1; DQ_i = 32'hDEAD;
        cycle();
        idle(); cycle();
        chk("t5_proto", err_proto_o, 1);
        hs_rdy_i = 1'b1;
        n_got = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (tk && n_got < 16) begin
                got_dt[n_got] = tk_dt; got_last[n_got] = tk_last; got_zlp[n_got] = tk_zlp;
                n_got++;
            end
        end
        chk("t5_count", n_got, 7);
        for (int i = 0; i < 7; i++) begin
            chk("t5_last", got_last[i], i >= 5);
            chk("t5_zlp", got_zlp[i], i == 6);
            chk("t5_data", got_dt[i], (i < 6) ? 32'h50 + i : 32'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = $urandom_range(0, 7);
            SLCSn_i   = ($urandom_range(0, 7) == 0);
            SLOEn_i   = $urandom_range(0, 1);
            PKTENDn_i = ($urandom_range(0, 5) != 0);
            DQ_i      = $urandom;
            h_wr_i    = $urandom_range(0, 1);
            h_dt_i    = $urandom;
            hs_rdy_i  = ($urandom_range(0, 2) != 0);
            if (op <= 2) begin
                SLRDn_i = 1'b0; SLWRn_i = 1'b1;
                SLADDR_i = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            end else if (op <= 5) begin
                SLRDn_i = 1'b1; SLWRn_i = 1'b0; SLADDR_i = 2'($urandom_range(0, 3));
            end else if (op == 6) begin
                SLRDn_i = 1'b0; SLWRn_i = 1'b0; SLADDR_i = 2'($urandom_range(0, 3));
            end else begin
                SLRDn_i = 1'b1; SLWRn_i = 1'b1; SLADDR_i = 2'($urandom_range(0, 3));
            end
            cycle();
        end
        idle();
        hs_rdy_i = 1'b1;
        repeat (60) cycle();
        chk("final_drained", hs_vld_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
